// File: rtl/shiftreg_load_ctrl.sv
// Configuration-chain load sequencer: shifts {stat_data, dyn_data} MSB first on sclk,
// then pulses the static and dynamic latch enables and raises the sticky enfin flag.
module shiftreg_load_ctrl #(
    parameter int DYN_W     = 16,
    parameter int STAT_W    = 88,
    parameter int DIV       = 2,
    parameter int LATCH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DYN_W-1:0]  dyn_data,
    input  logic [STAT_W-1:0] stat_data,
    output logic              busy,
    output logic              sclk,
    output logic              sdata,
    output logic              stat_le,
    output logic              dyn_le,
    output logic              enfin,
    output logic [2:0]        state_dbg
);

    localparam int N  = DYN_W + STAT_W;
    localparam int BW = $clog2(N);

    localparam logic [7:0]    DIV_M1   = 8'(DIV - 1);
    localparam logic [3:0]    LAT_M1   = 4'(LATCH_CYC - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH_S  = 3'd3,
        LATCH_D  = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [7:0]    phase, phase_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [3:0]    lat_cnt, lat_n;
    logic [N-1:0]  shadow, shadow_n;

    logic busy_n, sclk_n, sdata_n, stat_le_n, dyn_le_n, enfin_n;

    assign state_dbg = state;

    // Request semantics: start is a level sampled only in IDLE (no ready/ack);
    // abort dominates start, and is a no-op when nothing is in flight.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        bit_n    = bit_cnt;
        lat_n    = lat_cnt;
        shadow_n = shadow;
        enfin_n  = enfin;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    shadow_n = {stat_data, dyn_data};
                    enfin_n  = 1'b0;
                    phase_n  = '0;
                    bit_n    = '0;
                    lat_n    = '0;
                    state_n  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase == DIV_M1) begin
                    phase_n = '0;
                    state_n = SHIFT_HI;
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase == DIV_M1) begin
                    phase_n = '0;
                    if (bit_cnt == LAST_BIT) begin
                        lat_n   = '0;
                        state_n = LATCH_S;
                    end else begin
                        // Next bit appears on sdata in the same cycle sclk falls.
                        bit_n    = bit_cnt + 1'b1;
                        shadow_n = {shadow[N-2:0], 1'b0};
                        state_n  = SHIFT_LO;
                    end
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            LATCH_S: begin
                if (lat_cnt == LAT_M1) begin
                    lat_n   = '0;
                    state_n = LATCH_D;
                end else begin
                    lat_n = lat_cnt + 4'd1;
                end
            end
            LATCH_D: begin
                if (lat_cnt == LAT_M1) begin
                    lat_n   = '0;
                    enfin_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    lat_n = lat_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort drops straight to IDLE without touching enfin (it is already 0 mid-load).
        if (abort && state != IDLE) begin
            state_n = IDLE;
            phase_n = '0;
            bit_n   = '0;
            lat_n   = '0;
        end

        busy_n    = (state_n != IDLE);
        sclk_n    = (state_n == SHIFT_HI);
        stat_le_n = (state_n == LATCH_S);
        dyn_le_n  = (state_n == LATCH_D);
        sdata_n   = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? shadow_n[N-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            lat_cnt <= '0;
            shadow  <= '0;
            busy    <= 1'b0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            stat_le <= 1'b0;
            dyn_le  <= 1'b0;
            enfin   <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            lat_cnt <= lat_n;
            shadow  <= shadow_n;
            busy    <= busy_n;
            sclk    <= sclk_n;
            sdata   <= sdata_n;
            stat_le <= stat_le_n;
            dyn_le  <= dyn_le_n;
            enfin   <= enfin_n;
        end
    end

endmodule

// File: tb/tb_shiftreg_load_ctrl.sv
// Bench for shiftreg_load_ctrl: default instance plus a DIV=1/LATCH_CYC=1 instance,
// each cycle compared against a cycle-index model of the load waveform.
module tb_shiftreg_load_ctrl;

    localparam int DYN_W  = 16;
    localparam int STAT_W = 88;
    localparam int N      = DYN_W + STAT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start0, start1, abort;
    logic [DYN_W-1:0]  dyn_data;
    logic [STAT_W-1:0] stat_data;

    logic busy0, sclk0, sdata0, stat_le0, dyn_le0, enfin0;
    logic busy1, sclk1, sdata1, stat_le1, dyn_le1, enfin1;
    logic [2:0] state_dbg0, state_dbg1;
    logic [5:0] obs0, obs1;

    assign obs0 = {busy0, sclk0, sdata0, stat_le0, dyn_le0, enfin0};
    assign obs1 = {busy1, sclk1, sdata1, stat_le1, dyn_le1, enfin1};

    shiftreg_load_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .dyn_data(dyn_data), .stat_data(stat_data),
        .busy(busy0), .sclk(sclk0), .sdata(sdata0), .stat_le(stat_le0),
        .dyn_le(dyn_le0), .enfin(enfin0), .state_dbg(state_dbg0)
    );

    shiftreg_load_ctrl #(.DIV(1), .LATCH_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .dyn_data(dyn_data), .stat_data(stat_data),
        .busy(busy1), .sclk(sclk1), .sdata(sdata1), .stat_le(stat_le1),
        .dyn_le(dyn_le1), .enfin(enfin1), .state_dbg(state_dbg1)
    );

    int tests = 0;
    int fails = 0;
    logic [0:0] exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed={busy,sclk,sdata,sle,dle,enfin}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Expected {busy,sclk,sdata,stat_le,dyn_le,enfin} at cycle k after the start edge.
    function automatic logic [5:0] model(input int k, input int div, input int lc,
                                         input int stop, input logic [N-1:0] w);
        int nb, idx, ph;
        nb = 2 * div * N;
        if (stop > 0 && k > stop) return 6'b000000;
        if (k <= nb) begin
            idx = (k - 1) / (2 * div);
            ph  = (k - 1) % (2 * div);
            return {1'b1, (ph >= div), w[N-1-idx], 3'b000};
        end
        if (k <= nb + lc)     return 6'b100100;
        if (k <= nb + 2 * lc) return 6'b100010;
        return 6'b000001;
    endfunction

    function automatic logic [N-1:0] rand_w();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[N-1:0];
    endfunction

    // Starts a load on instance sel and checks every cycle up to the nominal completion
    // cycle; stop_cyc>0 asserts abort (or rst) during that cycle.
    task automatic run_load(input int sel, input string tag, input logic [N-1:0] w,
                            input int stop_cyc, input logic stop_is_rst, input logic noise);
        int div, lc, lat, edges;
        logic prev;
        logic [5:0] o, e;
        logic [0:0] bit_exp;
        div = (sel != 0) ? 1 : 2;
        lc  = (sel != 0) ? 1 : 2;
        lat = 1 + 2 * div * N + 2 * lc;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(w[N-1-i]);
        {stat_data, dyn_data} = w;
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        tick;
        start0 = 1'b0;
        start1 = 1'b0;
        edges  = 0;
        prev   = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            o = (sel != 0) ? obs1 : obs0;
            e = model(k, div, lc, stop_cyc, w);
            check($sformatf("%s_cyc%0d", tag, k), o, e);
            if (o[4] && !prev) begin
                edges++;
                if (exp_q.size() == 0) begin
                    check_int($sformatf("%s_extra_edge%0d", tag, edges), edges, N);
                end else begin
                    bit_exp = exp_q.pop_front();
                    check_int($sformatf("%s_bit%0d", tag, edges), int'(o[3]), int'(bit_exp));
                end
            end
            prev = o[4];
            if (noise && k == 50) begin
                if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
            end
            if (noise && k == 60) dyn_data = DYN_W'($urandom);
            if (k == stop_cyc) begin
                if (stop_is_rst) rst = 1'b1; else abort = 1'b1;
            end
            if (k < lat) begin
                tick;
                start0 = 1'b0;
                start1 = 1'b0;
                rst    = 1'b0;
                abort  = 1'b0;
            end
        end
        if (stop_cyc == 0) check_int({tag, "_edges"}, edges, N);
    endtask

    task automatic idle_check(input string tag, input logic [5:0] e, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check($sformatf("%s_%0d", tag, i), obs0, e);
            tick;
        end
    endtask

    logic [N-1:0] w_fixed;

    initial begin
        rst       = 1'b1;
        start0    = 1'b0;
        start1    = 1'b0;
        abort     = 1'b0;
        dyn_data  = '0;
        stat_data = '0;
        w_fixed   = {88'h8000000000000000000001, 16'hA5C3};

        repeat (3) tick;
        check("reset0", obs0, 6'b000000);
        check("reset1", obs1, 6'b000000);
        rst = 1'b0;
        tick;
        check("post_reset0", obs0, 6'b000000);
        check("post_reset1", obs1, 6'b000000);

        run_load(0, "fixed", w_fixed, 0, 1'b0, 1'b0);
        // Back-to-back: start accepted on the enfin-rise cycle, with mid-load noise.
        run_load(0, "noise", w_fixed, 0, 1'b0, 1'b1);
        tick;

        start0 = 1'b1;
        abort  = 1'b1;
        tick;
        start0 = 1'b0;
        abort  = 1'b0;
        idle_check("start_abort_done", 6'b000001, 3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        idle_check("abort_idle", 6'b000001, 2);

        run_load(0, "abort200", rand_w(), 200, 1'b0, 1'b0);
        tick;
        run_load(0, "after_abort", rand_w(), 0, 1'b0, 1'b0);
        tick;
        run_load(0, "abort_ls", rand_w(), 417, 1'b0, 1'b0);
        tick;
        run_load(0, "pre_rst", rand_w(), 0, 1'b0, 1'b0);
        tick;
        run_load(0, "rst300", rand_w(), 300, 1'b1, 1'b0);
        tick;

        start0 = 1'b1;
        abort  = 1'b1;
        tick;
        start0 = 1'b0;
        abort  = 1'b0;
        idle_check("start_abort_idle", 6'b000000, 3);

        run_load(1, "fast1", rand_w(), 0, 1'b0, 1'b0);
        run_load(1, "fast2", rand_w(), 0, 1'b0, 1'b0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
